// File: rtl/psk_phase_dispatcher.sv
// rtl/psk_phase_dispatcher.sv - BPSK/QPSK phase-transition counter with windowed valid/ready report
//
// Purpose:
//   A 16-bit NCO produces I/Q reference codes. Two saturating correlators
//   integrate the 1-bit input against them over DUMP_LEN samples. A small
//   tracker FSM counts alternating I/Q sign transitions between successive
//   dumps. After WIN_LEN dumps, the count is reported on out_data under a
//   valid/ready handshake. out_lost flags an overwritten window.
//
// Ports:
//   clk        in   rising-edge clock for all logic
//   rst_in     in   active-low reset; asserts asynchronously, release is synchronised to clk
//   sig        in   1-bit quantised input sample, one per clk
//   freq_word  in   16-bit NCO phase increment per clk
//   clr        in   synchronous clear of all state; wins over every other event
//   out_data   out  CNT_W-bit transition count of the last completed window
//   out_valid  out  out_data/out_lost are valid
//   out_ready  in   consumer accepts when out_valid && out_ready
//   out_lost   out  an unaccepted earlier window was overwritten
//
// Configuration:
//   PSK_DISP_SAT_EN  defined: the transition count saturates at 2^CNT_W-1
//                    undefined: the transition count wraps modulo 2^CNT_W

module psk_phase_dispatcher #(
  parameter int ACC_W    = 8,
  parameter int CNT_W    = 8,
  parameter int DUMP_LEN = 16,
  parameter int WIN_LEN  = 8
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             sig,
  input  logic [15:0]      freq_word,
  input  logic             clr,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lost
);

  localparam int SCNT_W = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
  localparam int DCNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_Q = 2'd2
  } state_t;

  // Reset synchroniser: both stages clear asynchronously, release ripples in over two clocks.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Saturating +/-1 step on a two's-complement accumulator.
  function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc, input logic mis);
    logic [ACC_W-1:0] res;
    if (mis) begin
      res = (acc == ACC_MIN) ? acc : acc - ACC_ONE;
    end else begin
      res = (acc == ACC_MAX) ? acc : acc + ACC_ONE;
    end
    return res;
  endfunction

  logic [15:0]       r_phase;
  logic [ACC_W-1:0]  r_i_acc;
  logic [ACC_W-1:0]  r_q_acc;
  logic              r_i_bit;
  logic              r_q_bit;
  logic [SCNT_W-1:0] r_samp_cnt;
  logic [DCNT_W-1:0] r_dump_cnt;
  logic [CNT_W-1:0]  r_cnt;
  state_t            r_state;
  logic [CNT_W-1:0]  r_out_data;
  logic              r_out_valid;
  logic              r_out_lost;

  logic              w_i_code;
  logic              w_q_code;
  logic [ACC_W-1:0]  w_i_acc_nx;
  logic [ACC_W-1:0]  w_q_acc_nx;
  logic              w_i_new;
  logic              w_q_new;
  logic              w_dump;
  logic              w_win_end;
  logic              w_hs;
  logic              w_inc;
  logic [CNT_W-1:0]  w_cnt_nx;
  state_t            w_state_nx;

  // Bit 15 of (phase + 0x4000) is phase[15] flipped by the carry out of bit 14.
  assign w_i_code = r_phase[15];
  assign w_q_code = r_phase[15] ^ r_phase[14];

  assign w_i_acc_nx = acc_step(r_i_acc, sig ^ w_i_code);
  assign w_q_acc_nx = acc_step(r_q_acc, sig ^ w_q_code);

  // Dump bits are the sign of the accumulator after the period's last sample.
  assign w_i_new   = w_i_acc_nx[ACC_W-1];
  assign w_q_new   = w_q_acc_nx[ACC_W-1];
  assign w_dump    = (r_samp_cnt == SCNT_W'(DUMP_LEN - 1));
  assign w_win_end = w_dump && (r_dump_cnt == DCNT_W'(WIN_LEN - 1));
  assign w_hs      = r_out_valid && out_ready;

  // NCO, correlators and dump/window counters.
  // r_i_bit/r_q_bit hold the last dump's bits and also serve as the "previous" bits for the tracker.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_phase    <= '0;
      r_i_acc    <= '0;
      r_q_acc    <= '0;
      r_i_bit    <= 1'b0;
      r_q_bit    <= 1'b0;
      r_samp_cnt <= '0;
      r_dump_cnt <= '0;
    end else if (clr) begin
      r_phase    <= '0;
      r_i_acc    <= '0;
      r_q_acc    <= '0;
      r_i_bit    <= 1'b0;
      r_q_bit    <= 1'b0;
      r_samp_cnt <= '0;
      r_dump_cnt <= '0;
    end else begin
      r_phase <= r_phase + freq_word;
      if (w_dump) begin
        r_i_acc    <= '0;
        r_q_acc    <= '0;
        r_i_bit    <= w_i_new;
        r_q_bit    <= w_q_new;
        r_samp_cnt <= '0;
        r_dump_cnt <= w_win_end ? '0 : r_dump_cnt + DCNT_W'(1);
      end else begin
        r_i_acc    <= w_i_acc_nx;
        r_q_acc    <= w_q_acc_nx;
        r_samp_cnt <= r_samp_cnt + SCNT_W'(1);
      end
    end
  end

  // Tracker next-state: alternately waits for an I flip then a Q flip; a
  // dump where both flip still counts once and advances one step only.
  always_comb begin
    w_state_nx = r_state;
    w_inc      = 1'b0;
    if (w_dump) begin
      case (r_state)
        ST_PRIME: begin
          w_state_nx = ST_WAIT_I;
        end
        ST_WAIT_I: begin
          if (w_i_new != r_i_bit) begin
            w_inc      = 1'b1;
            w_state_nx = ST_WAIT_Q;
          end
        end
        ST_WAIT_Q: begin
          if (w_q_new != r_q_bit) begin
            w_inc      = 1'b1;
            w_state_nx = ST_WAIT_I;
          end
        end
        default: begin
          w_state_nx = ST_PRIME;
        end
      endcase
    end
  end

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_inc) begin
`ifdef PSK_DISP_SAT_EN
      w_cnt_nx = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
`else
      w_cnt_nx = r_cnt + CNT_W'(1);
`endif
    end
  end

  // Tracker state, window count and report registers.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_PRIME;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_lost  <= 1'b0;
    end else if (clr) begin
      r_state     <= ST_PRIME;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_win_end) begin
        // Report includes this dump's increment; a pending unaccepted report is lost.
        r_cnt       <= '0;
        r_out_data  <= w_cnt_nx;
        r_out_valid <= 1'b1;
        r_out_lost  <= r_out_valid && !out_ready;
      end else begin
        r_cnt <= w_cnt_nx;
        if (w_hs) begin
          r_out_valid <= 1'b0;
          r_out_lost  <= 1'b0;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_lost  = r_out_lost;

endmodule

// File: tb/tb_psk_phase_dispatcher.sv
// tb/tb_psk_phase_dispatcher.sv - directed-vector bench for psk_phase_dispatcher (default and CNT_W=3 instances)

module tb_psk_phase_dispatcher;

  logic        clk       = 1'b0;
  logic        rst_in    = 1'b0;
  logic        sig       = 1'b0;
  logic        clr       = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] freq_word = 16'h0000;

  logic [7:0]  d8;
  logic        v8;
  logic        l8;
  logic [2:0]  d3;
  logic        v3;
  logic        l3;

  int n_vec = 0;
  int n_err = 0;
  int s     = 0;
  bit tog   = 1'b0;
  int n_edges;
  int exp_w2_3;

  always #5 clk = ~clk;

  psk_phase_dispatcher #(
    .ACC_W(8), .CNT_W(8), .DUMP_LEN(16), .WIN_LEN(8)
  ) u_dut8 (
    .clk(clk), .rst_in(rst_in), .sig(sig), .freq_word(freq_word), .clr(clr),
    .out_data(d8), .out_valid(v8), .out_ready(out_ready), .out_lost(l8)
  );

  psk_phase_dispatcher #(
    .ACC_W(8), .CNT_W(3), .DUMP_LEN(16), .WIN_LEN(8)
  ) u_dut3 (
    .clk(clk), .rst_in(rst_in), .sig(sig), .freq_word(freq_word), .clr(clr),
    .out_data(d3), .out_valid(v3), .out_ready(out_ready), .out_lost(l3)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sig is set for the sample taken at this edge; s is the sample index.
  task automatic tick();
    sig = (tog && s >= 0) ? s[4] : 1'b0;
    @(posedge clk);
    #1;
    s++;
  endtask

  task automatic run_to(input int target);
    while (s < target) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    s   = 0;
  endtask

  initial begin
`ifdef PSK_DISP_SAT_EN
    exp_w2_3 = 7;
`else
    exp_w2_3 = 0;
`endif
    for (int i = 0; i < 4; i++) tick();
    check_val("rst_valid", 32'(v8), 32'd0);
    check_val("rst_data",  32'(d8), 32'd0);
    check_val("rst_lost",  32'(l8), 32'd0);

    // Constant sig=0, freq_word=0: zero-count reports every 128 clocks.
    rst_in    = 1'b1;
    s         = -2;
    tog       = 1'b0;
    out_ready = 1'b1;
    run_to(127);
    check_val("const_w1_not_yet", 32'(v8), 32'd0);
    tick();
    check_val("const_w1_valid", 32'(v8), 32'd1);
    check_val("const_w1_data",  32'(d8), 32'd0);
    check_val("const_w1_lost",  32'(l8), 32'd0);
    run_to(255);
    check_val("const_w2_not_yet", 32'(v8), 32'd0);
    tick();
    check_val("const_w2_valid", 32'(v8), 32'd1);
    check_val("const_w2_data",  32'(d8), 32'd0);
    check_val("const_w2_lost",  32'(l8), 32'd0);

    // Toggling sig aligned to dumps, consumer always ready.
    tog = 1'b1;
    do_clr();
    run_to(128);
    check_val("tog_w1_valid", 32'(v8), 32'd1);
    check_val("tog_w1_data",  32'(d8), 32'd7);
    check_val("tog_w1_data3", 32'(d3), 32'd7);
    check_val("tog_w1_lost",  32'(l8), 32'd0);
    run_to(256);
    check_val("tog_w2_data",  32'(d8), 32'd8);
    check_val("tog_w2_data3", 32'(d3), 32'(exp_w2_3));
    run_to(384);
    check_val("tog_w3_data",  32'(d8), 32'd8);
    check_val("tog_w3_lost",  32'(l8), 32'd0);

    // Consumer stalls for two windows: second window overwrites, lost set.
    out_ready = 1'b0;
    do_clr();
    run_to(128);
    check_val("stall_w1_valid", 32'(v8), 32'd1);
    check_val("stall_w1_data",  32'(d8), 32'd7);
    check_val("stall_w1_lost",  32'(l8), 32'd0);
    run_to(256);
    check_val("stall_w2_valid", 32'(v8), 32'd1);
    check_val("stall_w2_data",  32'(d8), 32'd8);
    check_val("stall_w2_lost",  32'(l8), 32'd1);
    out_ready = 1'b1;
    tick();
    check_val("stall_hs_valid", 32'(v8), 32'd0);
    check_val("stall_hs_lost",  32'(l8), 32'd0);

    // Handshake coincident with window end: new data, valid stays, no loss.
    out_ready = 1'b0;
    do_clr();
    run_to(255);
    check_val("coinc_pre_valid", 32'(v8), 32'd1);
    out_ready = 1'b1;
    tick();
    check_val("coinc_valid", 32'(v8), 32'd1);
    check_val("coinc_data",  32'(d8), 32'd8);
    check_val("coinc_lost",  32'(l8), 32'd0);
    tick();
    check_val("coinc_after_valid", 32'(v8), 32'd0);

    // clr coincident with window end and ready: clr wins, tracker restarts in PRIME.
    do_clr();
    run_to(127);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    s   = 0;
    check_val("clr_valid", 32'(v8), 32'd0);
    check_val("clr_data",  32'(d8), 32'd0);
    run_to(128);
    check_val("clr_next_valid", 32'(v8), 32'd1);
    check_val("clr_next_data",  32'(d8), 32'd7);

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    out_ready = 1'b0;
    do_clr();
    run_to(140);
    check_val("arst_pre_valid", 32'(v8), 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    check_val("arst_valid", 32'(v8), 32'd0);
    check_val("arst_data",  32'(d8), 32'd0);
    check_val("arst_lost",  32'(l8), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    rst_in  = 1'b1;
    s       = -2;
    n_edges = 0;
    for (int i = 0; i < 400 && !v8; i++) begin
      tick();
      n_edges++;
    end
    // Two clocks to synchronise the release, then 128 sample clocks.
    check_val("arst_edges_to_valid", 32'(n_edges), 32'd130);
    check_val("arst_first_data",     32'(d8), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
